taillight_sequencer: RTL and testbench

Sequencing controller for the six-lamp rear-light cluster (left LA/LB/LC, right RA/RB/RC). It arbitrates turn-left, turn-right, hazard and brake requests and steps the lamp pattern at a prescaled animation rate. It replaces direct per-clock stepping of the turn FSM, so lamp timing is set by a parameter and not by the system clock.

---
 rtl/taillight_sequencer.sv | 147 ++++++++++++++
 tb/tb_taillight_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/taillight_sequencer.sv
// Rear-light cluster sequencer: arbitrates turn/hazard/brake requests and
// steps the six-lamp pattern once per prescaled animation tick.
module taillight_sequencer #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic L,
    input  logic R,
    input  logic H,
    input  logic B,
    output logic LA,
    output logic LB,
    output logic LC,
    output logic RA,
    output logic RB,
    output logic RC,
    output logic active,
    output logic step
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        L1     = 4'd1,
        L2     = 4'd2,
        L3     = 4'd3,
        R1     = 4'd4,
        R2     = 4'd5,
        R3     = 4'd6,
        HZ_ON  = 4'd7,
        HZ_OFF = 4'd8
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             b_q;
    logic             tick;
    logic             hz_req;
    logic [2:0]       lft;   // {LC, LB, LA}
    logic [2:0]       rgt;   // {RA, RB, RC}

    assign tick   = (cnt_q == CNT_MAX);
    assign hz_req = H | (L & R);

    // Free-running prescaler that defines the animation tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Brake is sampled every cycle so it responds independently of the tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_q <= 1'b0;
        end else begin
            b_q <= B;
        end
    end

    // State register; only advances on tick edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else if (tick) begin
            state_q <= state_d;
        end
    end

    // Next-state arbitration and Moore lamp decode with brake overlay.
    always_comb begin
        state_d = state_q;
        lft     = 3'b000;
        rgt     = 3'b000;
        unique case (state_q)
            IDLE: begin
                if (hz_req)  state_d = HZ_ON;
                else if (L)  state_d = L1;
                else if (R)  state_d = R1;
                if (b_q) begin
                    lft = 3'b111;
                    rgt = 3'b111;
                end
            end
            L1: begin
                state_d = hz_req ? HZ_ON : L2;
                lft     = 3'b001;
                if (b_q) rgt = 3'b111;
            end
            L2: begin
                state_d = hz_req ? HZ_ON : L3;
                lft     = 3'b011;
                if (b_q) rgt = 3'b111;
            end
            L3: begin
                state_d = hz_req ? HZ_ON : IDLE;
                lft     = 3'b111;
                if (b_q) rgt = 3'b111;
            end
            R1: begin
                state_d = hz_req ? HZ_ON : R2;
                rgt     = 3'b100;
                if (b_q) lft = 3'b111;
            end
            R2: begin
                state_d = hz_req ? HZ_ON : R3;
                rgt     = 3'b110;
                if (b_q) lft = 3'b111;
            end
            R3: begin
                state_d = hz_req ? HZ_ON : IDLE;
                rgt     = 3'b111;
                if (b_q) lft = 3'b111;
            end
            HZ_ON: begin
                state_d = HZ_OFF;
                lft     = 3'b111;
                rgt     = 3'b111;
            end
            HZ_OFF: begin
                state_d = hz_req ? HZ_ON : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output mapping from registered state only.
    assign LA     = lft[0];
    assign LB     = lft[1];
    assign LC     = lft[2];
    assign RA     = rgt[2];
    assign RB     = rgt[1];
    assign RC     = rgt[0];
    assign active = (state_q != IDLE);
    assign step   = tick;

endmodule

// File: tb/tb_taillight_sequencer.sv
// Scoreboard bench for taillight_sequencer at TICK_DIV=2: stimulus queues the
// expected lamp vector for each animation window, the monitor checks on step.
module tb_taillight_sequencer;

    localparam int unsigned TICK_DIV = 2;

    // Expected vectors: {active, LC, LB, LA, RA, RB, RC}
    localparam logic [6:0] E_IDLE  = 7'b0_000_000;
    localparam logic [6:0] E_L1    = 7'b1_001_000;
    localparam logic [6:0] E_L2    = 7'b1_011_000;
    localparam logic [6:0] E_L3    = 7'b1_111_000;
    localparam logic [6:0] E_R1    = 7'b1_000_100;
    localparam logic [6:0] E_R2    = 7'b1_000_110;
    localparam logic [6:0] E_HON   = 7'b1_111_111;
    localparam logic [6:0] E_HOFF  = 7'b1_000_000;
    localparam logic [6:0] E_BIDLE = 7'b0_111_111;
    localparam logic [6:0] E_BL1   = 7'b1_001_111;
    localparam logic [6:0] E_BL2   = 7'b1_011_111;
    localparam logic [6:0] E_BL3   = 7'b1_111_111;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic L = 1'b0, R = 1'b0, H = 1'b0, B = 1'b0;
    logic LA, LB, LC, RA, RB, RC, active, step;

    typedef struct {
        logic [6:0] vec;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    wire [6:0] obs = {active, LC, LB, LA, RA, RB, RC};

    always #5 clk = ~clk;

    taillight_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .L      (L),
        .R      (R),
        .H      (H),
        .B      (B),
        .LA     (LA),
        .LB     (LB),
        .LC     (LC),
        .RA     (RA),
        .RB     (RB),
        .RC     (RC),
        .active (active),
        .step   (step)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop one expectation per animation window.
    always @(negedge clk) begin
        if (step && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, 32'(obs), 32'(e.vec));
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step && n < 20);
        if (!step) begin
            failures++;
            $display("FAIL tick_timeout: no step within %0d cycles", n);
        end
    endtask

    // Drive requests sampled at the end of this window; queue next window's lamps.
    task automatic win(input logic l, input logic r, input logic h, input logic b,
                       input logic [6:0] exp, input string name);
        wait_tick();
        #1;
        L = l; R = r; H = h; B = b;
        sb.push_back('{exp, name});
    endtask

    initial begin
        int n;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("reset_lamps", 32'(obs), 32'(E_IDLE));
        chk("reset_step", 32'(step), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("step_pattern_%0d", i), 32'(step), 32'(i % 2));
        end
        win(0, 0, 0, 0, E_IDLE, "idle0");
        win(0, 0, 0, 0, E_IDLE, "idle1");

        // Held left turn, then release mid-sequence
        win(1, 0, 0, 0, E_L1,   "left_l1");
        win(1, 0, 0, 0, E_L2,   "left_l2");
        win(1, 0, 0, 0, E_L3,   "left_l3");
        win(1, 0, 0, 0, E_IDLE, "left_blank");
        win(1, 0, 0, 0, E_L1,   "left_repeat_l1");
        win(0, 0, 0, 0, E_L2,   "left_finish_l2");
        win(0, 0, 0, 0, E_L3,   "left_finish_l3");
        win(0, 0, 0, 0, E_IDLE, "left_end");
        win(0, 0, 0, 0, E_IDLE, "left_end_idle");

        // Right turn preempted by hazard at R2
        win(0, 1, 0, 0, E_R1,   "pre_r1");
        win(0, 1, 0, 0, E_R2,   "pre_r2");
        win(0, 0, 1, 0, E_HON,  "pre_hz_on");
        win(0, 0, 1, 0, E_HOFF, "pre_hz_off");
        win(0, 0, 0, 0, E_IDLE, "pre_exit");
        win(0, 0, 0, 0, E_IDLE, "pre_idle");

        // L and R together act as hazard
        win(1, 1, 0, 0, E_HON,  "lr_on0");
        win(1, 1, 0, 0, E_HOFF, "lr_off0");
        win(1, 1, 0, 0, E_HON,  "lr_on1");
        win(0, 0, 0, 0, E_HOFF, "lr_off1");
        win(0, 0, 0, 0, E_IDLE, "lr_exit");

        // Brake overlay in idle, left turn and hazard
        win(0, 0, 0, 1, E_BIDLE, "brk_idle");
        win(1, 0, 0, 1, E_BL1,   "brk_l1");
        win(1, 0, 0, 1, E_BL2,   "brk_l2");
        win(0, 0, 0, 1, E_BL3,   "brk_l3");
        win(0, 0, 0, 0, E_IDLE,  "brk_release");
        win(0, 0, 1, 1, E_HON,   "brk_hz_on");
        win(0, 0, 1, 1, E_HOFF,  "brk_hz_off");
        win(0, 0, 0, 1, E_BIDLE, "brk_hz_exit");
        win(0, 0, 0, 0, E_IDLE,  "brk_done");
        wait_tick();

        // Brake latency off-tick: one cycle, no combinational path
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (step && n < 10);
        #1 B = 1'b1;
        #1 chk("brake_no_comb", 32'(obs), 32'(E_IDLE));
        @(negedge clk);
        chk("brake_one_cycle", 32'(obs), 32'(E_BIDLE));
        #1 B = 1'b0;
        @(negedge clk);
        chk("brake_off_one_cycle", 32'(obs), 32'(E_IDLE));

        // Async reset in L3
        win(1, 0, 0, 0, E_L1, "rst_l1");
        win(1, 0, 0, 0, E_L2, "rst_l2");
        win(1, 0, 0, 0, E_L3, "rst_l3");
        wait_tick();
        #3 reset = 1'b0;
        #1;
        chk("async_reset_lamps", 32'(obs), 32'(E_IDLE));
        chk("async_reset_step", 32'(step), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (obs == E_IDLE && n < 10);
        chk("restart_edges", 32'(n), 32'(TICK_DIV));
        chk("restart_l1", 32'(obs), 32'(E_L1));
        L = 1'b0;
        repeat (8) @(posedge clk);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, 0 expected", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
